// File: rtl/fifo2audio.sv
// FIFO-to-codec playback serialiser: one FIFO word per daclrc frame, sent MSB-first, I2S one-bit delay.
// Build option FIFO2AUDIO_STEREO_DUP_EN: right channel repeats the left sample instead of silence.
module fifo2audio #(
   parameter int WIDTH = 16,
   parameter int CNTW  = 8
) (
   input  logic             bclk,
   input  logic             reset,
   input  logic             start2play,
   input  logic             daclrc,
   input  logic [WIDTH-1:0] rddata,
   input  logic             rdempty,
   output logic             rdclk,
   output logic             rdreq,
   output logic             dacdat,
   output logic             playing,
   output logic [CNTW-1:0]  underrun_cnt
);

   localparam int BW = $clog2(WIDTH) + 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_WAITFALL,
      S_LEFT,
      S_GAPL,
      S_RIGHT,
      S_GAPR
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_shift;
   logic [WIDTH-1:0] r_hold;
   logic [WIDTH-1:0] w_right_word;
   logic [BW-1:0]    r_bitcnt;
   logic             r_lrc_d;
   logic             r_empty;
   logic             w_fall;
   logic             w_rise;

   assign rdclk   = bclk;
   assign w_fall  = r_lrc_d & ~daclrc;
   assign w_rise  = ~r_lrc_d & daclrc;
   assign playing = (r_state != S_IDLE);

`ifdef FIFO2AUDIO_STEREO_DUP_EN
   assign w_right_word = r_hold;
`else
   assign w_right_word = '0;
`endif

   always_ff @(posedge bclk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      rdreq  = 1'b0;
      case (r_state)
         S_IDLE:     if (start2play && daclrc) w_next = S_FETCH;
         S_FETCH: begin
            rdreq  = ~rdempty;
            w_next = S_LOAD;
         end
         S_LOAD:     w_next = S_WAITFALL;
         S_WAITFALL: if (w_fall) w_next = S_LEFT;
         S_LEFT:     if (r_bitcnt == LAST_BIT) w_next = S_GAPL;
         S_GAPL:     if (w_rise) w_next = S_RIGHT;
         S_RIGHT:    if (r_bitcnt == LAST_BIT) w_next = S_GAPR;
         S_GAPR:     w_next = start2play ? S_FETCH : S_IDLE;
         default:    w_next = S_IDLE;
      endcase
   end

   // FIFO q arrives the cycle after rdreq, so hold is loaded in S_LOAD, not S_FETCH.
   always_ff @(posedge bclk or posedge reset) begin
      if (reset) begin
         r_lrc_d      <= 1'b0;
         r_shift      <= '0;
         r_hold       <= '0;
         r_bitcnt     <= '0;
         r_empty      <= 1'b0;
         underrun_cnt <= '0;
      end else begin
         r_lrc_d <= daclrc;
         case (r_state)
            S_FETCH: begin
               r_empty <= rdempty;
               if (rdempty && (underrun_cnt != '1))
                  underrun_cnt <= underrun_cnt + 1'b1;
            end
            S_LOAD: r_hold <= r_empty ? '0 : rddata;
            S_WAITFALL: begin
               if (w_fall) begin
                  r_shift  <= r_hold;
                  r_bitcnt <= '0;
               end
            end
            S_LEFT, S_RIGHT: begin
               r_shift  <= r_shift << 1;
               r_bitcnt <= r_bitcnt + 1'b1;
            end
            S_GAPL: begin
               if (w_rise) begin
                  r_shift  <= w_right_word;
                  r_bitcnt <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(negedge bclk or posedge reset) begin
      if (reset)
         dacdat <= 1'b0;
      else
         dacdat <= ((r_state == S_LEFT) || (r_state == S_RIGHT)) ? r_shift[WIDTH-1] : 1'b0;
   end

endmodule

// File: tb/tb_fifo2audio.sv
// Directed bench for fifo2audio: FIFO model, I2S receiver model and a frame scoreboard.
module tb_fifo2audio;

   localparam int WIDTH = 16;

   logic             bclk       = 1'b0;
   logic             reset      = 1'b0;
   logic             start2play = 1'b0;
   logic             daclrc     = 1'b0;
   logic [WIDTH-1:0] rddata     = '0;
   logic             rdempty    = 1'b1;
   logic             rdclk, rdreq, dacdat, playing;
   logic [7:0]       underrun_cnt;
   logic             rdclk2, rdreq2, dacdat2, playing2;
   logic [1:0]       underrun_cnt2;

   fifo2audio #(.WIDTH(WIDTH), .CNTW(8)) dut (
      .bclk(bclk), .reset(reset), .start2play(start2play), .daclrc(daclrc),
      .rddata(rddata), .rdempty(rdempty), .rdclk(rdclk), .rdreq(rdreq),
      .dacdat(dacdat), .playing(playing), .underrun_cnt(underrun_cnt)
   );

   // Narrow-counter twin sharing all inputs, used only for saturation.
   fifo2audio #(.WIDTH(WIDTH), .CNTW(2)) dut2 (
      .bclk(bclk), .reset(reset), .start2play(start2play), .daclrc(daclrc),
      .rddata(rddata), .rdempty(rdempty), .rdclk(rdclk2), .rdreq(rdreq2),
      .dacdat(dacdat2), .playing(playing2), .underrun_cnt(underrun_cnt2)
   );

   always #5 bclk = ~bclk;

   // 64fs codec: daclrc toggles every 32 bclk, on the falling edge.
   int lrc_cnt = 0;
   always @(negedge bclk) begin
      lrc_cnt = lrc_cnt + 1;
      if (lrc_cnt == 32) begin
         lrc_cnt = 0;
         daclrc  = ~daclrc;
      end
   end

   // FIFO model: q presented half a cycle after the posedge that accepts rdreq.
   logic [WIDTH-1:0] mem [0:15];
   int wr_ptr = 0, rd_ptr = 0;
   int rd_count = 0, rd_viol = 0, rd_dbl = 0;
   bit rd_pend = 1'b0, rdreq_prev = 1'b0;
   always @(negedge bclk) begin
      if (rd_pend) begin
         rddata  = mem[rd_ptr % 16];
         rd_ptr  = rd_ptr + 1;
         rd_pend = 1'b0;
      end
      if (rdreq === 1'b1) begin
         rd_count = rd_count + 1;
         if (rdempty) rd_viol = rd_viol + 1;
         else         rd_pend = 1'b1;
         if (rdreq_prev) rd_dbl = rd_dbl + 1;
      end
      rdreq_prev = (rdreq === 1'b1);
      rdempty    = (wr_ptr == rd_ptr);
   end

   // Codec receiver: samples on posedge, data starts one bclk after each daclrc edge.
   logic [16:0]      rx_q [$];
   logic [WIDTH-1:0] rx_word = '0;
   logic             rx_prev = 1'b0;
   bit               rx_ch = 1'b0, rx_sync = 1'b0, cap_en = 1'b0;
   int               rx_idx = WIDTH, gap_bad = 0;
   always @(posedge bclk) begin
      if (daclrc !== rx_prev) begin
         if (!cap_en) rx_sync = 1'b0;
         else if (daclrc == 1'b0) rx_sync = 1'b1;
         rx_ch   = daclrc;
         rx_idx  = 0;
         rx_word = '0;
         if (dacdat !== 1'b0) gap_bad = gap_bad + 1;
      end else if (rx_idx < WIDTH) begin
         rx_word = {rx_word[WIDTH-2:0], dacdat};
         rx_idx  = rx_idx + 1;
         if (rx_idx == WIDTH && rx_sync && cap_en) rx_q.push_back({rx_ch, rx_word});
      end else if (dacdat !== 1'b0) begin
         gap_bad = gap_bad + 1;
      end
      rx_prev = daclrc;
   end

   typedef struct {
      logic [16:0] cw;
      int          ur;
   } exp_t;
   exp_t exp_q [$];
   int   ur_cur = 0;
   int   checks = 0, passes = 0, fails = 0;
   int   rd_snap;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp) passes = passes + 1;
      else begin
         fails = fails + 1;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [WIDTH-1:0] w);
      exp_t e;
      mem[wr_ptr % 16] = w;
      wr_ptr = wr_ptr + 1;
      e.cw = {1'b0, w};
      e.ur = ur_cur;
      exp_q.push_back(e);
`ifdef FIFO2AUDIO_STEREO_DUP_EN
      e.cw = {1'b1, w};
`else
      e.cw = {1'b1, 16'h0000};
`endif
      exp_q.push_back(e);
   endtask

   task automatic fifo_only(input logic [WIDTH-1:0] w);
      mem[wr_ptr % 16] = w;
      wr_ptr = wr_ptr + 1;
   endtask

   task automatic expect_silence();
      exp_t e;
      ur_cur = ur_cur + 1;
      e.ur = ur_cur;
      e.cw = {1'b0, 16'h0000};
      exp_q.push_back(e);
      e.cw = {1'b1, 16'h0000};
      exp_q.push_back(e);
   endtask

   task automatic check_half(input string tag);
      exp_t        e;
      logic [16:0] got;
      int          n;
      n = 0;
      while (rx_q.size() == 0 && n < 200) begin
         @(negedge bclk);
         n = n + 1;
      end
      e = exp_q.pop_front();
      if (rx_q.size() == 0) begin
         check({tag, "_rx_timeout"}, {31'd0, rx_q.size() != 0}, 32'd1);
      end else begin
         got = rx_q.pop_front();
         check(tag, {15'd0, got}, {15'd0, e.cw});
         if (e.cw[16] == 1'b0) begin
            check({tag, "_ur8"}, {24'd0, underrun_cnt}, (e.ur > 255) ? 32'd255 : 32'(e.ur));
            check({tag, "_ur2"}, {30'd0, underrun_cnt2}, (e.ur > 3) ? 32'd3 : 32'(e.ur));
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 reset = 1'b1;
      start2play = 1'b1;
      load(16'hA5C3);
      repeat (3) @(negedge bclk);
      check("rst_dacdat",  {31'd0, dacdat},  32'd0);
      check("rst_rdreq",   {31'd0, rdreq},   32'd0);
      check("rst_playing", {31'd0, playing}, 32'd0);
      check("rst_ur8",     {24'd0, underrun_cnt},  32'd0);
      check("rst_ur2",     {30'd0, underrun_cnt2}, 32'd0);

      // Release during daclrc high: first word must land in the next left slot.
      @(posedge daclrc);
      repeat (4) @(negedge bclk);
      reset  = 1'b0;
      cap_en = 1'b1;
      repeat (3) @(negedge bclk);
      check("start_playing", {31'd0, playing}, 32'd1);

      for (int i = 0; i < 5; i++) expect_silence();
      for (int i = 0; i < 11; i++) check_half("frame_a");

      load(16'h8001);
      load(16'h7FFE);
      load(16'h0000);
      for (int i = 0; i < 6; i++) check_half("frame_b");
      load(16'h1234);
      check_half("frame_b");

      // Stop requested mid left word: the whole frame still goes out.
      @(negedge daclrc);
      repeat (5) @(negedge bclk);
      start2play = 1'b0;
      check_half("frame_stop");
      check_half("frame_stop");
      cap_en = 1'b0;
      repeat (4) @(negedge bclk);
      check("stop_playing", {31'd0, playing}, 32'd0);
      rd_snap = rd_count;
      fifo_only(16'hBEEF);
      repeat (130) @(negedge bclk);
      check("stop_no_rdreq", 32'(rd_count), 32'(rd_snap));
      check("stop_still_idle", {31'd0, playing}, 32'd0);
      check("rd_count_a", 32'(rd_count), 32'd5);

      // Restart, then reset in the middle of the left word.
      @(posedge daclrc);
      repeat (4) @(negedge bclk);
      start2play = 1'b1;
      @(negedge daclrc);
      repeat (8) @(posedge bclk);
      #1;
      check("pre_rst_dacdat", {31'd0, dacdat}, 32'd1);
      reset = 1'b1;
      #1;
      check("midrst_dacdat",  {31'd0, dacdat},  32'd0);
      check("midrst_rdreq",   {31'd0, rdreq},   32'd0);
      check("midrst_ur8",     {24'd0, underrun_cnt}, 32'd0);
      check("midrst_playing", {31'd0, playing}, 32'd0);
      ur_cur = 0;
      repeat (3) @(negedge bclk);
      reset = 1'b0;
      load(16'h0F0F);
      cap_en = 1'b1;
      check_half("frame_resync");
      start2play = 1'b0;
      check_half("frame_resync");
      repeat (4) @(negedge bclk);
      check("end_playing", {31'd0, playing}, 32'd0);

      check("rdreq_while_empty", 32'(rd_viol), 32'd0);
      check("rdreq_back_to_back", 32'(rd_dbl), 32'd0);
      check("gap_bits_zero", 32'(gap_bad), 32'd0);
      check("rd_count_total", 32'(rd_count), 32'd7);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
